// File: rtl/seg_mux_driver.sv
// -----------------------------------------------------------------------------
// seg_mux_driver
//   Time-multiplexed N-digit hex driver for a common-anode 7-segment display.
//   A value is captured into a staging register on load_i and copied to the
//   displayed (shadow) register only at the end of a full scan, so a digit
//   never shows a mix of old and new values within one frame. Each digit slot
//   begins with a short all-anodes-off interval to suppress ghosting.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   digits_i    hex value, nibble k drives digit k (digit 0 least significant)
//   load_i      capture strobe for digits_i
//   digit_en_i  per-digit enable, 0 keeps that digit dark
//   SegDisp     segments {g,f,e,d,c,b,a}, active-low, registered
//   DigitSel    anode enables, active-low, one-cold, registered
//   frame_done  one-clock pulse during the last clock of each full scan
// -----------------------------------------------------------------------------
module seg_mux_driver #(
  parameter int NUM_DIGITS   = 2,
  parameter int REFRESH_DIV  = 24000,
  parameter int BLANK_CYCLES = 240,
  parameter int LZ_BLANK     = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic                    load_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  output logic [6:0]              SegDisp,
  output logic [NUM_DIGITS-1:0]   DigitSel,
  output logic                    frame_done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] LAST_BLANK = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_ON    = 1'b1
  } state_t;

  // Hex to active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Scan state
  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    slot_end, frame_end;

  // Value path
  logic [4*NUM_DIGITS-1:0] staging_q, staging_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pending_q, pending_d;

  // Output registers
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;
  logic                    fd_q, fd_d;

  logic [NUM_DIGITS-1:0]   lead_dark;
  logic                    any_nz;

  // ---------------------------------------------------------------------------
  // Slot timing FSM: BLANK for the first BLANK_CYCLES clocks of a slot, then ON
  // until the slot counter wraps, at which point the digit index advances.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    idx_d     = idx_q;
    slot_end  = (cnt_q == LAST_CNT);
    frame_end = slot_end && (idx_q == LAST_IDX);

    case (state_q)
      ST_BLANK: if (cnt_q == LAST_BLANK) state_d = ST_ON;
      ST_ON:    if (slot_end)            state_d = ST_BLANK;
      default:                           state_d = ST_BLANK;
    endcase

    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Load / commit. A load on the frame-ending edge bypasses staging so the new
  // value is shown from the very next frame and nothing is left pending.
  // ---------------------------------------------------------------------------
  always_comb begin
    staging_d = staging_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;

    if (load_i) begin
      staging_d = digits_i;
      pending_d = 1'b1;
    end

    if (frame_end) begin
      if (load_i) begin
        shadow_d  = digits_i;
        pending_d = 1'b0;
      end else if (pending_q) begin
        shadow_d  = staging_q;
        pending_d = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero mask, scanned from the most significant digit downward.
  // Digit 0 is never masked so a zero value still shows "0".
  // ---------------------------------------------------------------------------
  always_comb begin
    lead_dark = '0;
    any_nz    = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      any_nz       = any_nz | (shadow_d[4*k +: 4] != 4'h0);
      lead_dark[k] = (LZ_BLANK != 0) && !any_nz;
    end
  end

  // ---------------------------------------------------------------------------
  // Output next-state. Outputs are computed from the next scan state so the
  // registered pins line up with the counter value of the same clock.
  // ---------------------------------------------------------------------------
  always_comb begin
    seg_d = 7'h7F;
    sel_d = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((idx_d == IDX_W'(k)) && (state_d == ST_ON) &&
          digit_en_i[k] && !lead_dark[k]) begin
        seg_d    = seg_decode(shadow_d[4*k +: 4]);
        sel_d[k] = 1'b0;
      end
    end
    fd_d = (idx_d == LAST_IDX) && (cnt_d == LAST_CNT);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_BLANK;
      cnt_q     <= '0;
      idx_q     <= '0;
      staging_q <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      seg_q     <= 7'h7F;
      sel_q     <= '1;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      sel_q     <= sel_d;
      fd_q      <= fd_d;
    end
  end

  assign SegDisp    = seg_q;
  assign DigitSel   = sel_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_mux_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_mux_driver
//   Directed stimulus against seg_mux_driver (2 digits, 8-clock slots, 2 blank
//   clocks). A frame-arithmetic model predicts every output on every clock;
//   literal expectations pin the model at selected clocks.
// -----------------------------------------------------------------------------
module tb_seg_mux_driver;

  localparam int N  = 2;
  localparam int RD = 8;
  localparam int BC = 2;
  localparam int F  = N * RD;

  logic       clk;
  logic       reset;
  logic [7:0] digits_i;
  logic       load_i;
  logic [1:0] digit_en_i;
  logic [6:0] SegDisp;
  logic [1:0] DigitSel;
  logic       frame_done;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [6:0] SEG [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  seg_mux_driver #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (RD),
    .BLANK_CYCLES(BC),
    .LZ_BLANK    (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .digits_i  (digits_i),
    .load_i    (load_i),
    .digit_en_i(digit_en_i),
    .SegDisp   (SegDisp),
    .DigitSel  (DigitSel),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Model state: clock index since reset release, staging/shown value, enables
  int         t_m;
  logic [7:0] stg_m, sh_m;
  logic       pend_m;
  logic [1:0] en_m;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      t_m    <= 0;
      stg_m  <= '0;
      sh_m   <= '0;
      pend_m <= 1'b0;
      en_m   <= '0;
    end else begin
      t_m  <= t_m + 1;
      en_m <= digit_en_i;
      if (load_i) begin
        stg_m  <= digits_i;
        pend_m <= 1'b1;
      end
      if ((t_m % F) == F - 1) begin
        if (load_i) begin
          sh_m   <= digits_i;
          pend_m <= 1'b0;
        end else if (pend_m) begin
          sh_m   <= stg_m;
          pend_m <= 1'b0;
        end
      end
    end
  end

  function automatic void exp_out(input int t, input logic [7:0] sh, input logic [1:0] en,
                                  output logic [6:0] s, output logic [1:0] d, output logic f);
    int         slot, pos;
    logic [3:0] nib;
    logic       lz;
    slot = (t / RD) % N;
    pos  = t % RD;
    nib  = 4'(sh >> (4 * slot));
    lz   = (slot > 0) && ((sh >> (4 * slot)) == 8'h00);
    f    = ((t % F) == F - 1);
    s    = 7'h7F;
    d    = 2'b11;
    if (pos >= BC && en[slot] && !lz) begin
      s = SEG[nib];
      d = ~(2'b01 << slot);
    end
  endfunction

  always @(negedge clk) begin : cmp
    logic [6:0] es;
    logic [1:0] ed;
    logic       ef;
    if (reset) begin
      es = 7'h7F;
      ed = 2'b11;
      ef = 1'b0;
    end else begin
      exp_out(t_m, sh_m, en_m, es, ed, ef);
    end
    chk("model_seg", 8'(SegDisp), 8'(es));
    chk("model_sel", 8'(DigitSel), 8'(ed));
    chk("model_fd", 8'(frame_done), 8'(ef));
  end

  task automatic step();
    @(negedge clk);
    cyc++;
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic show(input string nm, input logic [1:0] sel, input logic [6:0] seg);
    chk({nm, "_sel"}, 8'(DigitSel), 8'(sel));
    chk({nm, "_seg"}, 8'(SegDisp), 8'(seg));
  endtask

  initial begin
    reset      = 1'b1;
    load_i     = 1'b0;
    digits_i   = 8'h00;
    digit_en_i = 2'b11;
    repeat (3) @(negedge clk);
    #1;
    show("reset", 2'b11, 7'h7F);
    chk("reset_fd", 8'(frame_done), 8'h00);
    reset = 1'b0;
    cyc   = 0;

    // Power-up frame shows "0" on digit 0, and a load is staged mid-frame
    goto(1);  show("c1_blank", 2'b11, 7'h7F);
    goto(2);  show("c2_zero", 2'b10, 7'h40);
    goto(3);  load_i = 1'b1; digits_i = 8'h3A;
    goto(4);  load_i = 1'b0;
    goto(7);  show("c7_no_tear", 2'b10, 7'h40);
    goto(10); show("c10_lz", 2'b11, 7'h7F);
    goto(14); chk("fd_c14", 8'(frame_done), 8'h00);
    goto(15); chk("fd_c15", 8'(frame_done), 8'h01);

    // Committed 3A
    goto(18); show("3A_d0", 2'b10, 7'h08);
    goto(26); show("3A_d1", 2'b01, 7'h30);
    goto(31); chk("fd_c31", 8'(frame_done), 8'h01);

    // F1 loaded at clock 5 of frame 2 waits for the frame boundary
    goto(37); load_i = 1'b1; digits_i = 8'hF1;
    goto(38); load_i = 1'b0;
    goto(42); show("F1_hold_d1", 2'b01, 7'h30);
    goto(47); chk("fd_c47", 8'(frame_done), 8'h01);
    goto(50); show("F1_d0", 2'b10, 7'h79);
    goto(58); show("F1_d1", 2'b01, 7'h0E);

    // Load 05 on the frame-ending clock itself
    goto(63); chk("fd_c63", 8'(frame_done), 8'h01);
    load_i = 1'b1; digits_i = 8'h05;
    goto(64); load_i = 1'b0;
    goto(66); show("05_d0", 2'b10, 7'h12);
    goto(70); load_i = 1'b1; digits_i = 8'h00;
    goto(71); load_i = 1'b0;
    goto(74); show("05_d1_dark", 2'b11, 7'h7F);
    goto(82); show("00_d0", 2'b10, 7'h40);

    // Enables
    goto(85); load_i = 1'b1; digits_i = 8'h3A; digit_en_i = 2'b01;
    goto(86); load_i = 1'b0;
    goto(90);  show("00_d1_dark", 2'b11, 7'h7F);
    goto(98);  show("en01_d0", 2'b10, 7'h08);
    goto(106); show("en01_d1", 2'b11, 7'h7F);
    goto(111); chk("fd_c111", 8'(frame_done), 8'h01);
    goto(120); digit_en_i = 2'b10;
    goto(127); chk("fd_c127", 8'(frame_done), 8'h01);
    goto(130); show("en10_d0", 2'b11, 7'h7F);
    goto(138); show("en10_d1", 2'b01, 7'h30);
    goto(140); digit_en_i = 2'b11;

    // Asynchronous reset in the middle of slot 1 ON
    goto(155); show("pre_rst", 2'b01, 7'h30);
    reset = 1'b1;
    #1;
    show("async_rst", 2'b11, 7'h7F);
    chk("async_rst_fd", 8'(frame_done), 8'h00);
    step();
    step();
    reset = 1'b0;
    cyc   = 0;
    goto(2);  show("post_rst_d0", 2'b10, 7'h40);
    goto(10); show("post_rst_d1", 2'b11, 7'h7F);
    goto(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
